cpu_core_mc: RTL and testbench

//  Parametrised multi-cycle successor to the single-cycle puzzle CPU datapath: fetch/execute FSM

---
 rtl/cpu_core_pkg.sv | 43 ++++
 rtl/cpu_regfile.sv | 51 +++++
 rtl/cpu_core_mc.sv | 206 ++++++++++++++++++++
 tb/tb_cpu_core_mc.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_core_pkg.sv
// cpu_core_pkg -- shared definitions for the multi-cycle core.
//   Opcode encodings, FSM state enum, instruction field layout and a
//   small decode helper used by cpu_core_mc.
package cpu_core_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_LD   = 4'h9;
  localparam logic [3:0] OP_ST   = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_JZ   = 4'hC;
  localparam logic [3:0] OP_JNZ  = 4'hD;
  localparam logic [3:0] OP_CMP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MEM   = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  // [15:12] opc, [11:8] dst, [7:4] src0, [3:0] src1; imm8/target overlay [7:0]
  typedef struct packed {
    logic [3:0] opc;
    logic [3:0] dst;
    logic [3:0] src0;
    logic [3:0] src1;
  } instr_t;

  // Opcodes 1..7 write an ALU result to dst and update zf
  function automatic logic is_alu(input logic [3:0] opc);
    return (opc >= OP_ADD) && (opc <= OP_SHR);
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// cpu_regfile -- NREG x DW register file.
//   mclk/rst_n      : clock, async active-low reset (clears all registers)
//   we/waddr/wdata  : one synchronous write port
//   raddr0/rdata0   : async read port (src0)
//   raddr1/rdata1   : async read port (src1)
//   dbg_addr/dbg_rdata : async debug read port
// Addresses are a fixed 4-bit field; indices >= NREG read 0 and drop writes.
module cpu_regfile #(
  parameter int DW   = 40,
  parameter int NREG = 16
) (
  input  logic          mclk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [3:0]    waddr,
  input  logic [DW-1:0] wdata,
  input  logic [3:0]    raddr0,
  output logic [DW-1:0] rdata0,
  input  logic [3:0]    raddr1,
  output logic [DW-1:0] rdata1,
  input  logic [3:0]    dbg_addr,
  output logic [DW-1:0] dbg_rdata
);

  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

  logic [NREG-1:0][DW-1:0] regs_q, regs_d;

  function automatic logic [DW-1:0] rd(input logic [NREG-1:0][DW-1:0] r,
                                       input logic [3:0] a);
    logic [IW-1:0] ai;
    ai = IW'(a);
    return (int'(a) < NREG) ? r[ai] : '0;
  endfunction

  always_comb begin
    regs_d = regs_q;
    if (we && (int'(waddr) < NREG))
      regs_d[IW'(waddr)] = wdata;
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) regs_q <= '0;
    else        regs_q <= regs_d;
  end

  assign rdata0    = rd(regs_q, raddr0);
  assign rdata1    = rd(regs_q, raddr1);
  assign dbg_rdata = rd(regs_q, dbg_addr);

endmodule

// File: rtl/cpu_core_mc.sv
// cpu_core_mc -- multi-cycle fetch/execute core with req/ack data memory.
//   mclk, rst_n          : single clock, async active-low reset
//   run, step            : free-run / single-step control (step is edge-triggered)
//   imem_addr, imem_data : PC out, combinational instruction ROM in
//   dmem_*               : data memory request held until a one-cycle ack
//   halted, zf           : status
//   dbg_sel, dbg_data    : combinational register peek
// The FSM moves FETCH/EXEC only on the enable tick (once per 2^DIV_LOG2
// cycles); MEM completes on ack regardless of the tick.
module cpu_core_mc
  import cpu_core_pkg::*;
#(
  parameter int DW       = 40,
  parameter int AW       = 6,
  parameter int NREG     = 16,
  parameter int DAW      = 8,
  parameter int DIV_LOG2 = 0
) (
  input  logic           mclk,
  input  logic           rst_n,
  input  logic           run,
  input  logic           step,
  output logic [AW-1:0]  imem_addr,
  input  logic [15:0]    imem_data,
  output logic           dmem_req,
  output logic           dmem_we,
  output logic [DAW-1:0] dmem_addr,
  output logic [DW-1:0]  dmem_wdata,
  input  logic [DW-1:0]  dmem_rdata,
  input  logic           dmem_ack,
  output logic           halted,
  output logic           zf,
  input  logic [3:0]     dbg_sel,
  output logic [DW-1:0]  dbg_data
);

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  instr_t        ir_q, ir_d;
  logic          zf_q, zf_d;
  logic          step_q;
  logic          step_pend_q, step_pend_d;

  logic          tick, step_rise, go;
  logic          rf_we;
  logic [DW-1:0] rf_wdata, rf_rdata0, rf_rdata1, alu_res;
  logic [7:0]    imm8;
  logic [AW-1:0] target;

  // ---------------- enable tick ----------------
  generate
    if (DIV_LOG2 == 0) begin : g_tick_always
      assign tick = 1'b1;
    end else begin : g_tick_div
      logic [DIV_LOG2-1:0] tick_cnt_q, tick_cnt_d;
      assign tick_cnt_d = tick_cnt_q + 1'b1;
      assign tick       = &tick_cnt_q;
      always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) tick_cnt_q <= '0;
        else        tick_cnt_q <= tick_cnt_d;
      end
    end
  endgenerate

  // ---------------- step edge capture ----------------
  assign step_rise = step & ~step_q;
  // FETCH proceeds when free-running or a step edge is pending / arriving now
  assign go = run | step_pend_q | step_rise;

  // Edges are only remembered while parked in FETCH, so edges seen during
  // EXEC/MEM are dropped; the pending edge is consumed when FETCH advances.
  always_comb begin
    step_pend_d = step_pend_q;
    if (state_q == S_FETCH) begin
      if (tick && go)     step_pend_d = 1'b0;
      else if (step_rise) step_pend_d = 1'b1;
    end
  end

  // ---------------- register file ----------------
  cpu_regfile #(.DW(DW), .NREG(NREG)) u_rf (
    .mclk      (mclk),
    .rst_n     (rst_n),
    .we        (rf_we),
    .waddr     (ir_q.dst),
    .wdata     (rf_wdata),
    .raddr0    (ir_q.src0),
    .rdata0    (rf_rdata0),
    .raddr1    (ir_q.src1),
    .rdata1    (rf_rdata1),
    .dbg_addr  (dbg_sel),
    .dbg_rdata (dbg_data)
  );

  // ---------------- ALU ----------------
  assign imm8   = {ir_q.src0, ir_q.src1};
  assign target = AW'(imm8);

  always_comb begin
    alu_res = '0;
    case (ir_q.opc)
      OP_ADD:         alu_res = rf_rdata0 + rf_rdata1;
      OP_SUB, OP_CMP: alu_res = rf_rdata0 - rf_rdata1;
      OP_AND:         alu_res = rf_rdata0 & rf_rdata1;
      OP_OR:          alu_res = rf_rdata0 | rf_rdata1;
      OP_XOR:         alu_res = rf_rdata0 ^ rf_rdata1;
      OP_SHL:         alu_res = {rf_rdata0[DW-2:0], 1'b0};
      OP_SHR:         alu_res = {1'b0, rf_rdata0[DW-1:1]};
      default:        alu_res = '0;
    endcase
  end

  // ---------------- state register ----------------
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      pc_q        <= '0;
      ir_q        <= '0;
      zf_q        <= 1'b0;
      step_q      <= 1'b0;
      step_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      zf_q        <= zf_d;
      step_q      <= step;
      step_pend_q <= step_pend_d;
    end
  end

  // ---------------- next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: if (tick && go) state_d = S_EXEC;
      S_EXEC: begin
        if (tick) begin
          case (ir_q.opc)
            OP_LD, OP_ST: state_d = S_MEM;
            OP_HALT:      state_d = S_HALT;
            default:      state_d = S_FETCH;
          endcase
        end
      end
      S_MEM:   if (dmem_ack) state_d = S_FETCH;
      default: state_d = S_HALT;
    endcase
  end

  // ---------------- datapath updates ----------------
  always_comb begin
    pc_d     = pc_q;
    ir_d     = ir_q;
    zf_d     = zf_q;
    rf_we    = 1'b0;
    rf_wdata = alu_res;
    case (state_q)
      S_FETCH: if (tick && go) ir_d = instr_t'(imem_data);
      S_EXEC: begin
        if (tick) begin
          pc_d = pc_q + 1'b1;   // wraps modulo 2^AW
          if (is_alu(ir_q.opc)) begin
            rf_we = 1'b1;
            zf_d  = (alu_res == '0);
          end
          case (ir_q.opc)
            OP_LDI: begin
              rf_we    = 1'b1;
              rf_wdata = {{(DW-8){1'b0}}, imm8};
            end
            OP_JMP: pc_d = target;
            OP_JZ:  if (zf_q)  pc_d = target;
            OP_JNZ: if (!zf_q) pc_d = target;
            OP_CMP: zf_d = (alu_res == '0);
            default: ;
          endcase
        end
      end
      S_MEM: begin
        if (dmem_ack && (ir_q.opc == OP_LD)) begin
          rf_we    = 1'b1;
          rf_wdata = dmem_rdata;
        end
      end
      default: ;
    endcase
  end

  // ---------------- outputs ----------------
  // Request is a pure decode of state so an async reset drops it at once.
  always_comb begin
    dmem_req = (state_q == S_MEM);
    dmem_we  = (state_q == S_MEM) && (ir_q.opc == OP_ST);
    halted   = (state_q == S_HALT);
  end

  assign imem_addr  = pc_q;
  assign zf         = zf_q;
  assign dmem_addr  = rf_rdata1[DAW-1:0];
  assign dmem_wdata = rf_rdata0;

  logic unused_addr_hi;
  assign unused_addr_hi = ^rf_rdata1[DW-1:DAW];

endmodule

// File: tb/tb_cpu_core_mc.sv
`timescale 1ns/1ps
module tb_cpu_core_mc;

  localparam int DW = 40;
  localparam int AW = 6;

  logic          mclk = 1'b0;
  logic          rst_n, run, step;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_data;
  logic          dmem_req, dmem_we, dmem_ack;
  logic [7:0]    dmem_addr;
  logic [DW-1:0] dmem_wdata, dmem_rdata;
  logic          halted, zf;
  logic [3:0]    dbg_sel;
  logic [DW-1:0] dbg_data;

  logic [15:0] rom [64];
  int n_cmp = 0;
  int n_err = 0;

  always #5 mclk = ~mclk;
  assign imem_data = rom[imem_addr];

  cpu_core_mc #(.DW(DW), .AW(AW), .NREG(16), .DAW(8), .DIV_LOG2(0)) dut (
    .mclk(mclk), .rst_n(rst_n), .run(run), .step(step),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .halted(halted), .zf(zf), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input int idx, input logic [63:0] exp);
    dbg_sel = 4'(idx);
    #0.1;
    chk(tag, 64'(dbg_data), exp);
  endtask

  // advance n rising edges, then settle 1ns past the edge
  task automatic cyc(input int n);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  task automatic clr_rom();
    for (int i = 0; i < 64; i++) rom[i] = 16'h0000;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b1; step = 1'b0; dmem_ack = 1'b0;
    dmem_rdata = '0; dbg_sel = '0;
    clr_rom();

    // ---- reset state ----
    cyc(2);
    chk("rst_pc", 64'(imem_addr), 0);
    chk("rst_req", 64'(dmem_req), 0);
    chk("rst_we", 64'(dmem_we), 0);
    chk("rst_halted", 64'(halted), 0);
    chk("rst_zf", 64'(zf), 0);
    for (int i = 0; i < 16; i++) chk_reg($sformatf("rst_r%0d", i), i, 0);

    // ---- branch, load, store, spurious ack, halt ----
    rom[0] = 16'h8105; rom[1] = 16'h8205; rom[2] = 16'h2312; rom[3] = 16'hC007;
    rom[7] = 16'h8410; rom[8] = 16'h9504; rom[9] = 16'hA014;
    rom[10] = 16'h8622; rom[11] = 16'hF000;
    do_reset();
    cyc(8);
    chk("jz_pc", 64'(imem_addr), 7);
    chk("jz_zf", 64'(zf), 1);
    chk_reg("sub_r3", 3, 0);
    chk_reg("ldi_r1", 1, 5);
    chk_reg("ldi_r2", 2, 5);
    cyc(4);
    chk("ld_req", 64'(dmem_req), 1);
    chk("ld_we", 64'(dmem_we), 0);
    chk("ld_addr", 64'(dmem_addr), 64'h10);
    chk("ld_pc", 64'(imem_addr), 9);
    cyc(2);
    chk("ld_req_hold", 64'(dmem_req), 1);
    dmem_rdata = 40'h12_3456_789A;
    dmem_ack = 1'b1;
    cyc(1);
    dmem_ack = 1'b0;
    chk("ld_req_drop", 64'(dmem_req), 0);
    chk_reg("ld_r5", 5, 64'h12_3456_789A);
    chk("ld_zf_kept", 64'(zf), 1);
    cyc(2);
    chk("st_req", 64'(dmem_req), 1);
    chk("st_we", 64'(dmem_we), 1);
    chk("st_wdata", 64'(dmem_wdata), 5);
    chk("st_addr", 64'(dmem_addr), 64'h10);
    cyc(2);
    chk("st_req_hold", 64'(dmem_req), 1);
    chk("st_wdata_hold", 64'(dmem_wdata), 5);
    dmem_ack = 1'b1;
    cyc(1);
    dmem_ack = 1'b0;
    chk("st_req_drop", 64'(dmem_req), 0);
    dmem_ack = 1'b1;            // spurious ack while idle
    cyc(2);
    dmem_ack = 1'b0;
    chk("spur_pc", 64'(imem_addr), 11);
    chk("spur_req", 64'(dmem_req), 0);
    chk_reg("spur_r6", 6, 64'h22);
    cyc(2);
    chk("halt_flag", 64'(halted), 1);
    chk("halt_pc", 64'(imem_addr), 12);
    cyc(5);
    chk("halt_pc_frozen", 64'(imem_addr), 12);
    chk("halt_still", 64'(halted), 1);

    // ---- ALU patterns ----
    clr_rom();
    rom[0] = 16'h81C3; rom[1] = 16'h825A; rom[2] = 16'h3312; rom[3] = 16'h4412;
    rom[4] = 16'h5512; rom[5] = 16'h6610; rom[6] = 16'h7710; rom[7] = 16'h1812;
    rom[8] = 16'h2921; rom[9] = 16'hE011; rom[10] = 16'hD020; rom[11] = 16'hF000;
    do_reset();
    cyc(30);
    chk_reg("and", 3, 64'h42);
    chk_reg("or", 4, 64'hDB);
    chk_reg("xor", 5, 64'h99);
    chk_reg("shl", 6, 64'h186);
    chk_reg("shr", 7, 64'h61);
    chk_reg("add", 8, 64'h11D);
    chk_reg("sub_wrap", 9, 64'hFF_FFFF_FF97);
    chk("cmp_zf", 64'(zf), 1);
    chk("jnz_not_taken_pc", 64'(imem_addr), 12);
    chk("alu_halted", 64'(halted), 1);

    // ---- single-step ----
    clr_rom();
    rom[0] = 16'h8101; rom[1] = 16'h8202; rom[2] = 16'h8303;
    run = 1'b0;
    do_reset();
    cyc(5);
    chk("step_wait_pc", 64'(imem_addr), 0);
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      cyc(1);
      step = 1'b0;
      cyc(4);
      chk($sformatf("step%0d_pc", i), 64'(imem_addr), 64'(i + 1));
    end
    cyc(6);
    chk("step_parked_pc", 64'(imem_addr), 3);
    chk_reg("step_r3", 3, 3);
    run = 1'b1;

    // ---- PC wrap ----
    clr_rom();
    do_reset();
    cyc(126);
    chk("wrap_pc63", 64'(imem_addr), 63);
    cyc(2);
    chk("wrap_pc0", 64'(imem_addr), 0);

    // ---- async reset during MEM ----
    rom[0] = 16'h9500;
    do_reset();
    cyc(2);
    chk("mem_req_pre", 64'(dmem_req), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mem_req_async_drop", 64'(dmem_req), 0);
    cyc(1);
    rst_n = 1'b1;
    dmem_ack = 1'b1;            // stale ack of the aborted request
    cyc(1);
    dmem_ack = 1'b0;
    chk("stale_ack_req", 64'(dmem_req), 0);
    cyc(1);
    chk("remem_req", 64'(dmem_req), 1);
    chk("remem_pc", 64'(imem_addr), 1);
    chk_reg("stale_r5", 5, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
